// File: rtl/count_sequencer.sv
// Prescaled up-counter sequencer with one-shot and periodic run modes.
// Configuration is captured at start; done/wrap are single-cycle registered pulses.
module count_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [WIDTH-1:0] term,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic             mode;
    logic [WIDTH-1:0] term;
    logic [PRE_W-1:0] prescale;
  } cfg_t;

  state_t           state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] count_d;
  logic             busy_d, done_d, wrap_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      pre_q   <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      pre_q   <= pre_d;
      count   <= count_d;
      busy    <= busy_d;
      done    <= done_d;
      wrap    <= wrap_d;
    end
  end

  // Next-state and next-output logic; abort outranks any tick
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    pre_d   = pre_q;
    count_d = count;
    busy_d  = busy;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        pre_d  = '0;
        busy_d = 1'b0;
        if (start && !abort) begin
          cfg_d.mode     = mode;
          cfg_d.term     = term;
          cfg_d.prescale = prescale;
          count_d        = '0;
          state_d        = RUN;
          busy_d         = 1'b1;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          pre_d   = '0;
        end else if (pre_q == cfg_q.prescale) begin
          pre_d = '0;
          if (count != cfg_q.term) begin
            count_d = count + WIDTH'(1);
          end else if (!cfg_q.mode) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule
